// File: rtl/sd_cmd_pkg.sv
// Shared definitions for the SD command-layer sequencer: FSM states, response
// types and the bit positions of the 48-bit command/response frames.
package sd_cmd_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StSend,
      StWaitResp,
      StAck,
      StDone
   } state_e;

   localparam logic [1:0] RESP_NONE = 2'd0;  // no response expected
   localparam logic [1:0] RESP_R1   = 2'd1;  // 48-bit, index checked (R1/R6/R7)
   localparam logic [1:0] RESP_R2   = 2'd2;  // 136-bit (CID/CSD)
   localparam logic [1:0] RESP_R3   = 2'd3;  // 48-bit, no index check (OCR)

   // Outgoing command field (CRC and end bit are appended by cmd_phys)
   localparam int unsigned START_BIT = 39;
   localparam int unsigned TX_BIT    = 38;
   localparam int unsigned IDX_MSB   = 37;
   localparam int unsigned IDX_LSB   = 32;

   // Command index echoed in a 48-bit response
   localparam int unsigned RSP_IDX_MSB = 45;
   localparam int unsigned RSP_IDX_LSB = 40;

   // Start bit 0, transmission bit 1 (host to card), index, argument
   function automatic logic [39:0] build_cmd(input logic [5:0]  index,
                                             input logic [31:0] argument);
      logic [39:0] frame;
      frame                   = '0;
      frame[START_BIT]        = 1'b0;
      frame[TX_BIT]           = 1'b1;
      frame[IDX_MSB:IDX_LSB]  = index;
      frame[31:0]             = argument;
      return frame;
   endfunction

endpackage

// File: rtl/sd_timeout_counter.sv
// Saturating cycle counter used to bound the SEND and WAIT_RESP phases.
// expired is high once TIMEOUT_CYCLES-1 has been reached and stays high until cleared.
module sd_timeout_counter #(
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter int unsigned TO_WIDTH       = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [TO_WIDTH-1:0] LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

   logic [TO_WIDTH-1:0] count_q;

   // Count while enabled, stop at LAST so the value never wraps
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count_q <= '0;
      end else if (enable && (count_q != LAST)) begin
         count_q <= count_q + TO_WIDTH'(1);
      end
   end

   assign expired = (count_q == LAST);

endmodule

// File: rtl/sd_cmd_master.sv
// SD command-layer sequencer: accepts a host command request, hands the
// 40-bit command field to cmd_phys, waits for and checks the response, and
// reports completion with status flags and a formatted 128-bit response.
module sd_cmd_master
   import sd_cmd_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter int unsigned TO_WIDTH       = 8
) (
   input  logic         sd_clock,
   input  logic         reset,
   // host side
   input  logic         new_cmd,
   input  logic [5:0]   cmd_index,
   input  logic [31:0]  cmd_argument,
   input  logic [1:0]   resp_type,
   output logic         cmd_busy,
   output logic         cmd_complete,
   output logic [127:0] response_out,
   output logic         timeout_error,
   output logic         index_error,
   output logic         end_bit_error,
   // cmd_phys side
   output logic [39:0]  cmd_to_send,
   output logic         strobe_in,
   output logic         ack_in,
   output logic         idle_in,
   input  logic         ack_out,
   input  logic         strobe_out,
   input  logic [135:0] response,
   input  logic         COMMAND_TIMEOUT
);

   state_e         state_q, state_d;
   logic [5:0]     index_q, index_d;
   logic [1:0]     resp_type_q, resp_type_d;
   logic [39:0]    cmd_to_send_d;
   logic [127:0]   response_out_d;
   logic           timeout_error_d, index_error_d, end_bit_error_d;
   logic           to_clear, to_enable, to_expired;

   // Bits above the R2 payload carry the start/tx/reserved bits, not reported
   logic unused_resp_hi;
   assign unused_resp_hi = ^response[135:128];

   // Counter restarts on every state change and only runs in the bounded phases
   assign to_clear  = (state_d != state_q);
   assign to_enable = (state_q == StSend) || (state_q == StWaitResp);

   sd_timeout_counter #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .TO_WIDTH       (TO_WIDTH)
   ) u_timeout (
      .clk     (sd_clock),
      .reset   (reset),
      .clear   (to_clear),
      .enable  (to_enable),
      .expired (to_expired)
   );

   // State and latched command/result registers
   always_ff @(posedge sd_clock) begin
      if (reset) begin
         state_q       <= StIdle;
         index_q       <= '0;
         resp_type_q   <= RESP_NONE;
         cmd_to_send   <= '0;
         response_out  <= '0;
         timeout_error <= 1'b0;
         index_error   <= 1'b0;
         end_bit_error <= 1'b0;
      end else begin
         state_q       <= state_d;
         index_q       <= index_d;
         resp_type_q   <= resp_type_d;
         cmd_to_send   <= cmd_to_send_d;
         response_out  <= response_out_d;
         timeout_error <= timeout_error_d;
         index_error   <= index_error_d;
         end_bit_error <= end_bit_error_d;
      end
   end

   // Next-state, handshake outputs and result capture
   always_comb begin
      state_d         = state_q;
      index_d         = index_q;
      resp_type_d     = resp_type_q;
      cmd_to_send_d   = cmd_to_send;
      response_out_d  = response_out;
      timeout_error_d = timeout_error;
      index_error_d   = index_error;
      end_bit_error_d = end_bit_error;
      cmd_busy        = 1'b1;
      cmd_complete    = 1'b0;
      strobe_in       = 1'b0;
      ack_in          = 1'b0;
      idle_in         = 1'b0;

      unique case (state_q)
         StIdle: begin
            cmd_busy = 1'b0;
            idle_in  = 1'b1;
            if (new_cmd) begin
               index_d         = cmd_index;
               resp_type_d     = resp_type;
               cmd_to_send_d   = build_cmd(cmd_index, cmd_argument);
               response_out_d  = '0;
               timeout_error_d = 1'b0;
               index_error_d   = 1'b0;
               end_bit_error_d = 1'b0;
               state_d         = StSend;
            end
         end

         StSend: begin
            strobe_in = 1'b1;
            // An acknowledge on the last allowed cycle still counts
            if (ack_out) begin
               state_d = (resp_type_q == RESP_NONE) ? StDone : StWaitResp;
            end else if (to_expired) begin
               timeout_error_d = 1'b1;
               state_d         = StDone;
            end
         end

         StWaitResp: begin
            // A response arriving together with a timeout is still taken
            if (strobe_out) begin
               end_bit_error_d = ~response[0];
               if (resp_type_q == RESP_R2) begin
                  response_out_d = response[127:0];
               end else begin
                  response_out_d = {96'b0, response[39:8]};
               end
               if (resp_type_q == RESP_R1) begin
                  index_error_d = (response[RSP_IDX_MSB:RSP_IDX_LSB] != index_q);
               end
               state_d = StAck;
            end else if (COMMAND_TIMEOUT || to_expired) begin
               timeout_error_d = 1'b1;
               state_d         = StDone;
            end
         end

         StAck: begin
            ack_in = 1'b1;
            if (!strobe_out) begin
               state_d = StDone;
            end
         end

         StDone: begin
            cmd_complete = 1'b1;
            state_d      = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

endmodule

// File: tb/tb_sd_cmd_master.sv
// Self-checking bench for sd_cmd_master. Each command is described by its
// phys-side timing (ack delay, response delay/hold, early timeout); the bench
// derives phase lengths, flags and the formatted response arithmetically.
module tb_sd_cmd_master;

   localparam int T    = 64;
   localparam int NONE = 1000;  // "never" for delays

   logic         sd_clock = 1'b0;
   logic         reset;
   logic         new_cmd;
   logic [5:0]   cmd_index;
   logic [31:0]  cmd_argument;
   logic [1:0]   resp_type;
   logic         cmd_busy;
   logic         cmd_complete;
   logic [127:0] response_out;
   logic         timeout_error;
   logic         index_error;
   logic         end_bit_error;
   logic [39:0]  cmd_to_send;
   logic         strobe_in;
   logic         ack_in;
   logic         idle_in;
   logic         ack_out;
   logic         strobe_out;
   logic [135:0] response;
   logic         COMMAND_TIMEOUT;

   int n_cmp = 0;
   int n_err = 0;

   // Values the DUT must still be holding when the next command is accepted
   logic [39:0]  prev_cmd;
   logic [127:0] prev_resp;
   logic [2:0]   prev_flags;

   always #5 sd_clock = ~sd_clock;

   sd_cmd_master #(
      .TIMEOUT_CYCLES (T),
      .TO_WIDTH       (8)
   ) dut (
      .sd_clock        (sd_clock),
      .reset           (reset),
      .new_cmd         (new_cmd),
      .cmd_index       (cmd_index),
      .cmd_argument    (cmd_argument),
      .resp_type       (resp_type),
      .cmd_busy        (cmd_busy),
      .cmd_complete    (cmd_complete),
      .response_out    (response_out),
      .timeout_error   (timeout_error),
      .index_error     (index_error),
      .end_bit_error   (end_bit_error),
      .cmd_to_send     (cmd_to_send),
      .strobe_in       (strobe_in),
      .ack_in          (ack_in),
      .idle_in         (idle_in),
      .ack_out         (ack_out),
      .strobe_out      (strobe_out),
      .response        (response),
      .COMMAND_TIMEOUT (COMMAND_TIMEOUT)
   );

   // Runs one command starting in an IDLE cycle; returns in the IDLE cycle after DONE.
   // d: SEND cycle carrying ack_out; s/h: WAIT cycle where strobe_out rises and
   // how long it stays up; c: WAIT cycle of a COMMAND_TIMEOUT pulse.
   task automatic run_cmd(input string name, input logic [1:0] rt, input logic [5:0] idx,
                          input logic [31:0] arg, input int d, input bit s_en, input int s,
                          input int h, input int c, input logic [135:0] resp);
      int          send_len, wait_len, ack_len, tlim, done_k, w0;
      bit          tmo, cap;
      logic [39:0]  exp_cmd, exp_cmd_k;
      logic [127:0] exp_resp;
      logic [2:0]   exp_flags, act_flags;
      logic [4:0]   exp_ctrl, act_ctrl;

      exp_cmd  = {2'b01, idx, arg};
      send_len = (d < T) ? d + 1 : T;
      tmo      = (d >= T);
      cap      = 1'b0;
      wait_len = 0;
      ack_len  = 0;
      if (!tmo && rt != 2'd0) begin
         tlim = (c < T - 1) ? c : T - 1;
         if (s_en && s <= tlim) begin
            cap      = 1'b1;
            wait_len = s + 1;
            ack_len  = h;
         end else begin
            tmo      = 1'b1;
            wait_len = tlim + 1;
         end
      end
      w0     = 1 + send_len;
      done_k = 1 + send_len + wait_len + ack_len;

      exp_resp  = '0;
      exp_flags = {tmo, 2'b00};
      if (cap) begin
         exp_resp     = (rt == 2'd2) ? resp[127:0] : {96'b0, resp[39:8]};
         exp_flags[1] = (rt == 2'd1) && (resp[45:40] != idx);
         exp_flags[0] = ~resp[0];
      end

      for (int k = 0; k <= done_k; k++) begin
         if (k == 0) begin
            new_cmd      = 1'b1;
            cmd_index    = idx;
            cmd_argument = arg;
            resp_type    = rt;
         end else begin
            // Requests while busy must be ignored
            new_cmd      = 1'($urandom_range(0, 1));
            cmd_index    = 6'($urandom);
            cmd_argument = $urandom;
            resp_type    = 2'($urandom);
         end
         ack_out         = (d < T) && (k == 1 + d);
         strobe_out      = cap && (k >= w0 + s) && (k < w0 + s + h);
         COMMAND_TIMEOUT = (rt != 2'd0) && (k == w0 + c);
         response        = resp;
         @(negedge sd_clock);

         // {busy, strobe_in, ack_in, idle_in, complete}
         if (k == 0)                                     exp_ctrl = 5'b00010;
         else if (k <= send_len)                         exp_ctrl = 5'b11000;
         else if (k <= send_len + wait_len)              exp_ctrl = 5'b10000;
         else if (k <= send_len + wait_len + ack_len)    exp_ctrl = 5'b10100;
         else                                            exp_ctrl = 5'b10001;
         act_ctrl = {cmd_busy, strobe_in, ack_in, idle_in, cmd_complete};
         n_cmp++;
         if (act_ctrl !== exp_ctrl) begin
            n_err++;
            $display("FAIL %s ctrl k=%0d: got %b expected %b", name, k, act_ctrl, exp_ctrl);
         end

         exp_cmd_k = (k == 0) ? prev_cmd : exp_cmd;
         n_cmp++;
         if (cmd_to_send !== exp_cmd_k) begin
            n_err++;
            $display("FAIL %s cmd_to_send k=%0d: got %h expected %h", name, k, cmd_to_send,
                     exp_cmd_k);
         end

         act_flags = {timeout_error, index_error, end_bit_error};
         if (k == 0) begin
            n_cmp++;
            if (act_flags !== prev_flags || response_out !== prev_resp) begin
               n_err++;
               $display("FAIL %s held result: got %b/%h expected %b/%h", name, act_flags,
                        response_out, prev_flags, prev_resp);
            end
         end
         if (k == done_k) begin
            n_cmp++;
            if (act_flags !== exp_flags) begin
               n_err++;
               $display("FAIL %s flags {to,idx,end}: got %b expected %b", name, act_flags,
                        exp_flags);
            end
            n_cmp++;
            if (response_out !== exp_resp) begin
               n_err++;
               $display("FAIL %s response_out: got %h expected %h", name, response_out,
                        exp_resp);
            end
         end
         @(posedge sd_clock);
         #1;
      end
      new_cmd         = 1'b0;
      ack_out         = 1'b0;
      strobe_out      = 1'b0;
      COMMAND_TIMEOUT = 1'b0;
      prev_cmd        = exp_cmd;
      prev_resp       = exp_resp;
      prev_flags      = exp_flags;
   endtask

   function automatic logic [135:0] rand_resp();
      logic [159:0] rnd;
      rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
      return rnd[135:0];
   endfunction

   task automatic test_reset();
      logic [4:0] ctrl;
      reset = 1'b1;
      new_cmd = 1'b1;
      cmd_index = 6'd5;
      cmd_argument = 32'h1234_5678;
      resp_type = 2'd1;
      ack_out = 1'b0;
      strobe_out = 1'b0;
      COMMAND_TIMEOUT = 1'b0;
      response = '0;
      @(posedge sd_clock);
      @(posedge sd_clock);
      @(negedge sd_clock);
      ctrl = {cmd_busy, strobe_in, ack_in, idle_in, cmd_complete};
      n_cmp++;
      if (ctrl !== 5'b00010) begin
         n_err++;
         $display("FAIL reset ctrl: got %b expected 00010", ctrl);
      end
      n_cmp++;
      if (cmd_to_send !== 40'h0 || response_out !== 128'h0 ||
          {timeout_error, index_error, end_bit_error} !== 3'b000) begin
         n_err++;
         $display("FAIL reset regs: got cmd %h resp %h flags %b expected zeros", cmd_to_send,
                  response_out, {timeout_error, index_error, end_bit_error});
      end
      reset = 1'b0;
      new_cmd = 1'b0;
      @(posedge sd_clock);
      #1;
      prev_cmd = '0;
      prev_resp = '0;
      prev_flags = '0;
   endtask

   task automatic test_cmd0();
      run_cmd("cmd0", 2'd0, 6'd0, 32'h0, 3, 1'b0, 0, 1, NONE, rand_resp());
      n_cmp++;
      if (cmd_to_send !== 40'h40_0000_0000) begin
         n_err++;
         $display("FAIL cmd0 frame: got %h expected 4000000000", cmd_to_send);
      end
   endtask

   task automatic test_cmd17();
      logic [135:0] r;
      r = rand_resp();
      r[45:40] = 6'd17;
      r[39:8] = 32'h0000_0900;
      r[0] = 1'b1;
      run_cmd("cmd17", 2'd1, 6'd17, 32'h0000_0200, 0, 1'b1, 2, 3, NONE, r);
   endtask

   task automatic test_cmd17_bad();
      logic [135:0] r;
      r = rand_resp();
      r[45:40] = 6'd16;
      r[0] = 1'b0;
      run_cmd("cmd17_bad", 2'd1, 6'd17, 32'h0000_0200, 1, 1'b1, 0, 1, NONE, r);
   endtask

   task automatic test_cmd2();
      logic [135:0] r;
      r = {8'h3F, 128'hA5A5_A5A5_A5A5_A5A5_5A5A_5A5A_5A5A_5A5B};
      run_cmd("cmd2", 2'd2, 6'd2, 32'h0, 2, 1'b1, 4, 2, NONE, r);
   endtask

   task automatic test_timeouts();
      run_cmd("cmd8_noresp", 2'd1, 6'd8, 32'h1AA, 0, 1'b0, 0, 1, NONE, rand_resp());
      run_cmd("cmd8_cmdto", 2'd1, 6'd8, 32'h1AA, 0, 1'b0, 0, 1, 5, rand_resp());
      run_cmd("cmd8_coincide", 2'd1, 6'd8, 32'h1AA, 0, 1'b1, 5, 1, 5, rand_resp());
      run_cmd("send_timeout", 2'd3, 6'd41, 32'h40FF_8000, T, 1'b0, 0, 1, NONE, rand_resp());
      run_cmd("ack_last", 2'd3, 6'd41, 32'h40FF_8000, T - 1, 1'b1, T - 1, 1, NONE, rand_resp());
   endtask

   task automatic test_reset_mid();
      logic [4:0] ctrl;
      new_cmd = 1'b1;
      cmd_index = 6'd8;
      cmd_argument = 32'h0000_01AA;
      resp_type = 2'd1;
      @(posedge sd_clock);
      #1;
      new_cmd = 1'b0;
      ack_out = 1'b1;
      @(posedge sd_clock);
      #1;
      ack_out = 1'b0;
      new_cmd = 1'b1;
      cmd_index = 6'd33;
      cmd_argument = 32'hDEAD_BEEF;
      @(negedge sd_clock);
      ctrl = {cmd_busy, strobe_in, ack_in, idle_in, cmd_complete};
      n_cmp++;
      if (ctrl !== 5'b10000 || cmd_to_send !== {2'b01, 6'd8, 32'h0000_01AA}) begin
         n_err++;
         $display("FAIL busy ignore: got %b/%h expected 10000/%h", ctrl, cmd_to_send,
                  {2'b01, 6'd8, 32'h0000_01AA});
      end
      @(posedge sd_clock);
      #1;
      new_cmd = 1'b0;
      reset = 1'b1;
      @(posedge sd_clock);
      #1;
      reset = 1'b0;
      @(negedge sd_clock);
      ctrl = {cmd_busy, strobe_in, ack_in, idle_in, cmd_complete};
      n_cmp++;
      if (ctrl !== 5'b00010) begin
         n_err++;
         $display("FAIL mid reset ctrl: got %b expected 00010", ctrl);
      end
      n_cmp++;
      if (cmd_to_send !== 40'h0 || response_out !== 128'h0 ||
          {timeout_error, index_error, end_bit_error} !== 3'b000) begin
         n_err++;
         $display("FAIL mid reset regs: got cmd %h resp %h flags %b expected zeros",
                  cmd_to_send, response_out, {timeout_error, index_error, end_bit_error});
      end
      @(posedge sd_clock);
      #1;
      prev_cmd = '0;
      prev_resp = '0;
      prev_flags = '0;
   endtask

   task automatic test_back_to_back();
      run_cmd("b2b_a", 2'd3, 6'd58, 32'hCAFE_F00D, 0, 1'b1, 0, 1, NONE, rand_resp());
      run_cmd("b2b_b", 2'd0, 6'd7, 32'h1357_9BDF, 0, 1'b0, 0, 1, NONE, rand_resp());
      run_cmd("b2b_c", 2'd2, 6'd9, 32'h0, 1, 1'b1, 1, 2, NONE, rand_resp());
   endtask

   task automatic test_random();
      logic [1:0]   rt;
      logic [5:0]   idx;
      logic [135:0] r;
      int d, s, h, c;
      bit s_en;
      for (int n = 0; n < 40; n++) begin
         rt  = 2'($urandom);
         idx = 6'($urandom);
         d   = ($urandom_range(0, 9) == 0) ? T - 1 + int'($urandom_range(0, 1))
                                           : int'($urandom_range(0, 4));
         s_en = ($urandom_range(0, 7) != 0);
         s   = ($urandom_range(0, 9) == 0) ? T - 1 : int'($urandom_range(0, 6));
         h   = int'($urandom_range(1, 3));
         c   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : NONE;
         r   = rand_resp();
         if (rt == 2'd1 && $urandom_range(0, 1) == 1) r[45:40] = idx;
         run_cmd("random", rt, idx, $urandom, d, s_en, s, h, c, r);
      end
   endtask

   initial begin
      test_reset();
      test_cmd0();
      test_cmd17();
      test_cmd17_bad();
      test_cmd2();
      test_timeouts();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sd_cmd_master.md
Name: sd_cmd_master

Overview:
Command-layer sequencer that drives the cmd_phys physical layer on behalf of the host register file. It accepts a command request (index, argument, response type) and builds the 40-bit command field. It runs the strobe/ack handshakes with cmd_phys, enforces a response timeout and checks the returned response. It then reports completion with status flags and a formatted 128-bit response.

Parameters:
TIMEOUT_CYCLES, 64, max sd_clock cycles allowed in SEND or WAIT_RESP before timeout (≥2)
TO_WIDTH, 8, timeout counter width; TIMEOUT_CYCLES ≤ 2**TO_WIDTH

Ports:
sd_clock  in  1  sole clock
reset  in  1  synchronous, active-high
new_cmd  in  1  request; sampled only in IDLE
cmd_index  in  6  command index
cmd_argument  in  32  command argument
resp_type  in  2  0=none, 1=48-bit w/ index check (R1/R6/R7), 2=136-bit (R2), 3=48-bit no index check (R3)
cmd_busy  out  1  high in every state except IDLE
cmd_complete  out  1  one-cycle pulse in DONE
response_out  out  128  formatted response, held until next accept
timeout_error  out  1  valid with cmd_complete, held until next accept
index_error  out  1  same
end_bit_error  out  1  same
cmd_to_send  out  40  to cmd_phys
strobe_in  out  1  to cmd_phys: command request
ack_in  out  1  to cmd_phys: response consumed
idle_in  out  1  to cmd_phys: idle
ack_out  in  1  from cmd_phys: command accepted
strobe_out  in  1  from cmd_phys: response available
response  in  136  from cmd_phys
COMMAND_TIMEOUT  in  1  from cmd_phys timeout flag

Behaviour:
- Reset (sync, any state, mid-operation included): state IDLE; all outputs 0 except idle_in=1; latched fields, counter and flags cleared.
- States: IDLE, SEND, WAIT_RESP, ACK, DONE.
- IDLE: idle_in=1. If new_cmd=1: latch index/argument/resp_type; clear error flags and response_out; cmd_to_send <= {1'b0,1'b1,cmd_index,cmd_argument}; go to SEND next cycle. new_cmd is ignored in all other states.
- SEND: strobe_in=1, idle_in=0. On ack_out=1, strobe_in drops next cycle.
  - resp_type=0 -> DONE.
  - otherwise -> WAIT_RESP.
  - If the counter reaches TIMEOUT_CYCLES-1 without ack_out: timeout_error=1 -> DONE.
- WAIT_RESP: counter restarts at 0 on entry and increments each cycle.
  - strobe_out=1: capture response and go to ACK.
  - Else COMMAND_TIMEOUT=1 or counter==TIMEOUT_CYCLES-1: timeout_error=1 -> DONE.
  - strobe_out and a timeout in the same cycle: strobe_out wins.
- Capture rules, applied on the capture cycle:
  - resp_type 1/3: response_out = {96'b0, response[39:8]}; end_bit_error = ~response[0].
  - resp_type 1 only: index_error = (response[45:40] != latched index).
  - resp_type 2: response_out = response[127:0]; end_bit_error = ~response[0].
- ACK: ack_in=1, held until strobe_out=0, then DONE next cycle.
- DONE: cmd_complete=1 for exactly one cycle -> IDLE. idle_in returns to 1 in IDLE.
- Latency, no-response command with ack_out on the first SEND cycle: new_cmd (cycle 0) -> SEND (1) -> DONE (2) -> cmd_complete seen at cycle 2.
- Counter saturates and never wraps; it is cleared on every state entry.
- cmd_to_send is stable from SEND entry until the next accept.

Decomposition:
- Package sd_cmd_pkg:
  - state encoding;
  - RESP_NONE/RESP_R1/RESP_R2/RESP_R3 constants;
  - frame field positions (START_BIT=39, TX_BIT=38, IDX_MSB=37, IDX_LSB=32, RSP_IDX 45:40).
- Sub-module sd_timeout_counter (clear, enable, saturating count, expired flag), parameterised by TIMEOUT_CYCLES and TO_WIDTH.

Test Plan:
- CMD0: index 0, resp_type 0, ack_out after 3 cycles -> cmd_to_send=40'h40_0000_0000; cmd_complete pulses; no response phase; all errors 0.
- CMD17: arg 32'h0000_0200, resp_type 1; strobe_out with response[45:40]=17, [39:8]=32'h0000_0900, bit0=1 -> response_out[31:0]=32'h0000_0900; errors 0; ack_in held until strobe_out falls.
- CMD17 returning index 16 with bit0=0 -> index_error=1, end_bit_error=1, timeout_error=0.
- CMD2: resp_type 2, response[127:0]=128'hA5…5A -> response_out equals it; no index check.
- CMD8, resp_type 1, no strobe_out -> timeout_error=1 after TIMEOUT_CYCLES in WAIT_RESP. Repeat with COMMAND_TIMEOUT pulsed at cycle 5 -> early timeout. Repeat with strobe_out and timeout coincident -> response accepted.
- Reset asserted in WAIT_RESP -> next cycle IDLE, idle_in=1, strobe_in=ack_in=0; new_cmd during busy is ignored (cmd_to_send unchanged).
